// File: rtl/csa_pkg.sv
// csa_pkg: shared types and helpers for the carry-save accumulator slice.
//   state_t   : accumulator phase (ACC absorb, RES resolve, OUT present).
//   DEF_W     : default operand/accumulator width.
//   DEF_CHUNK : default bits resolved per carry-propagate cycle.
//   nch()     : number of chunks in a W-bit word.
//   idx_w()   : width of a counter indexing n items (at least 1 bit).
package csa_pkg;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        RES = 2'd1,
        OUT = 2'd2
    } state_t;

    localparam int DEF_W     = 92;
    localparam int DEF_CHUNK = 23;

    function automatic int nch(input int w, input int chunk);
        return (chunk > 0) ? (w / chunk) : 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csa_acc_if.sv
// csa_acc_if: operand/result handshake bundle for csa_acc.
//   in_valid/in_ready/in_data/in_last : operand beat stream, in_last closes a group.
//   out_valid/out_ready/out_sum       : resolved sum (mod 2^W) handshake.
//   out_ovf                           : true sum >= 2^W, present only when
//                                       CSA_ACC_OVF_EN is defined.
//   modport slave  : accumulator side.
//   modport master : producer/consumer side.
interface csa_acc_if
    import csa_pkg::*;
#(
    parameter int W = DEF_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
`ifdef CSA_ACC_OVF_EN
    logic         out_ovf;
`endif

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum
`ifdef CSA_ACC_OVF_EN
        , out_ovf
`endif
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum
`ifdef CSA_ACC_OVF_EN
        , out_ovf
`endif
    );

endinterface

// File: rtl/csa_3to2.sv
// csa_3to2: combinational W-bit 3:2 compressor.
//   a, b, d : addends.
//   s       : bitwise sum a^b^d.
//   c       : majority carries already shifted left by one (LSB is 0),
//             truncated to W bits so that a+b+d == s+c (mod 2^W).
//   cdrop   : majority bit W-1, the carry shifted out of the word.
module csa_3to2
    import csa_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] d,
    output logic [W-1:0] s,
    output logic [W-1:0] c,
    output logic         cdrop
);

    logic [W-1:0] maj;

    assign s     = a ^ b ^ d;
    assign maj   = (a & b) | (a & d) | (b & d);
    assign cdrop = maj[W-1];

    generate
        if (W > 1) begin : g_shift
            assign c = {maj[W-2:0], 1'b0};
        end else begin : g_narrow
            assign c = '0;
        end
    endgenerate

endmodule

// File: rtl/csa_acc.sv
// csa_acc: carry-save accumulator with chunked multi-cycle resolve.
//   clk  : rising-edge clock.
//   rst  : asynchronous active-high reset, discards any group in flight.
//   bus  : csa_acc_if.slave -- operand beats in, resolved sum out.
//   busy : high whenever the accumulator is not in its absorb phase.
// Beats are folded into a redundant sum/carry pair with one 3:2 level per
// cycle; the last beat of a group starts an NCH-cycle carry-propagate pass
// that resolves CHUNK bits per cycle, LSB chunk first.
// Optional feature macro: CSA_ACC_OVF_EN adds the out_ovf flag (sticky OR of
// every carry dropped off the top of the word plus the final resolve carry).
module csa_acc
    import csa_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic       clk,
    input  logic       rst,
    csa_acc_if.slave   bus,
    output logic       busy
);

    localparam int NCH = nch(W, CHUNK);
    localparam int KW  = idx_w(NCH);

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("csa_acc: CHUNK must be at least 1");
        end else if ((W % CHUNK) != 0) begin : g_bad_split
            $error("csa_acc: W must be a multiple of CHUNK");
        end
    endgenerate

    state_t          state;
    logic [W-1:0]    s_q;
    logic [W-1:0]    c_q;
    logic [W-1:0]    r_q;
    logic [KW-1:0]   k_q;
    logic            cy_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [W-1:0]    s_nx;
    logic [W-1:0]    c_nx;
    logic            drop;
    logic            acc_fire;
    logic            last_ch;

    int              sh;
    logic [CHUNK-1:0] s_ch;
    logic [CHUNK-1:0] c_ch;
    logic [CHUNK:0]   ch_sum;

    // ACC stage: one compressor level folds the beat into the redundant pair.
    csa_3to2 #(.W(W)) u_csa (
        .a     (s_q),
        .b     (c_q),
        .d     (bus.in_data),
        .s     (s_nx),
        .c     (c_nx),
        .cdrop (drop)
    );

    assign acc_fire = bus.in_valid && in_ready_q;
    assign last_ch  = (k_q == KW'(NCH - 1));

    // RES stage: a single CHUNK-bit adder walks the word, carrying cy between
    // cycles so no W-wide carry chain exists.
    always_comb begin
        sh     = int'(k_q) * CHUNK;
        s_ch   = CHUNK'(s_q >> sh);
        c_ch   = CHUNK'(c_q >> sh);
        ch_sum = {1'b0, s_ch} + {1'b0, c_ch} + {{CHUNK{1'b0}}, cy_q};
    end

`ifdef CSA_ACC_OVF_EN
    logic ovf_q;
`else
    // Without the overflow feature the dropped carry is intentionally discarded.
    logic unused_drop;
    assign unused_drop = drop;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACC;
            s_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            cy_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
`ifdef CSA_ACC_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ACC: begin
                    if (acc_fire) begin
                        s_q <= s_nx;
                        c_q <= c_nx;
`ifdef CSA_ACC_OVF_EN
                        ovf_q <= ovf_q | drop;
`endif
                        if (bus.in_last) begin
                            state      <= RES;
                            k_q        <= '0;
                            cy_q       <= 1'b0;
                            in_ready_q <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end
                RES: begin
                    // r_q is all-zero on entry, so OR-ing in each chunk builds the result.
                    r_q  <= r_q | (W'(ch_sum[CHUNK-1:0]) << sh);
                    cy_q <= ch_sum[CHUNK];
                    k_q  <= k_q + 1'b1;
                    if (last_ch) begin
                        state       <= OUT;
                        out_valid_q <= 1'b1;
`ifdef CSA_ACC_OVF_EN
                        ovf_q <= ovf_q | ch_sum[CHUNK];
`endif
                    end
                end
                // OUT stage: hold the result until the consumer takes it.
                OUT: begin
                    if (bus.out_ready) begin
                        state       <= ACC;
                        s_q         <= '0;
                        c_q         <= '0;
                        r_q         <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy        <= 1'b0;
`ifdef CSA_ACC_OVF_EN
                        ovf_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state       <= ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = r_q;
`ifdef CSA_ACC_OVF_EN
    assign bus.out_ovf   = out_valid_q & ovf_q;
`endif

endmodule

// File: tb/tb_csa_acc.sv
// tb_csa_acc: scoreboard bench for csa_acc. Groups of operands are summed
// with plain wide arithmetic; the expected (sum mod 2^W, sum >= 2^W) pair is
// queued when a group is issued and popped by a monitor on each output
// handshake. Directed groups cover the boundary cases, then random groups
// run with random gaps and random consumer backpressure.
module tb_csa_acc;
    import csa_pkg::*;

    localparam int W     = 92;
    localparam int CHUNK = 23;
    localparam int NCH   = W / CHUNK;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    csa_acc_if #(.W(W)) bus ();

    csa_acc #(.W(W), .CHUNK(CHUNK)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         ovf;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] beats_q[$];

    logic rdy_rand = 1'b0;
    logic drv_rdy  = 1'b1;
    logic rnd_rdy  = 1'b1;

    assign bus.out_ready = rdy_rand ? rnd_rdy : drv_rdy;

    always @(posedge clk) begin
        #1;
        rnd_rdy <= ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [95:0] raw;
        raw = {$urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return W'(1) << $urandom_range(0, W - 1);
            default: return W'(raw);
        endcase
    endfunction

    // Issue the operands in beats_q as one group; optionally queue the expected result.
    task automatic send_group(input bit push, input bit gaps);
        logic [W+7:0] tot;
        int n;
        tot = '0;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got in_ready=%b, expected 1", bus.in_ready);
        end
        for (int i = 0; i < beats_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = beats_q[i];
            bus.in_last  = (i == beats_q.size() - 1);
            tick();
            tot = tot + (W+8)'(beats_q[i]);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (push) begin
            exp_t e;
            e.sum = tot[W-1:0];
            e.ovf = ((tot >> W) != 0);
            expq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy=%b, expected 0", busy);
        end
    endtask

    // Monitor: every accepted output is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got sum %0h, expected no output", bus.out_sum);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("out_sum", bus.out_sum, e.sum);
`ifdef CSA_ACC_OVF_EN
                chk("out_ovf", W'(bus.out_ovf), W'(e.ovf));
`endif
            end
        end
`ifdef CSA_ACC_OVF_EN
        if (rst === 1'b0 && bus.out_valid === 1'b0) begin
            chk("out_ovf_idle", W'(bus.out_ovf), '0);
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] v;
        int n;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  W'(bus.in_ready),  W'(1));
        chk("rst_out_valid", W'(bus.out_valid), '0);
        chk("rst_out_sum",   bus.out_sum,       '0);
        chk("rst_busy",      W'(busy),          '0);
`ifdef CSA_ACC_OVF_EN
        chk("rst_out_ovf",   W'(bus.out_ovf),   '0);
`endif
        tick();

        // Single beat: latency from the accepting edge to out_valid.
        drv_rdy = 1'b1;
        beats_q = {W'(5)};
        send_group(1'b1, 1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("latency", W'(n), W'(NCH));
        wait_idle();

        // Carry ripple across the first chunk boundary.
        v = (W'(1) << 23) - W'(1);
        beats_q = {v, W'(1)};
        send_group(1'b1, 1'b0);
        wait_idle();

        // Carry ripple through every chunk and out of the word.
        v = '1;
        beats_q = {v, W'(1)};
        send_group(1'b1, 1'b0);
        wait_idle();

        // Overflow through the carry dropped off the compressor's top bit.
        v = W'(1) << 91;
        beats_q = {v, v, W'(1)};
        send_group(1'b1, 1'b0);
        wait_idle();

        // Backpressure: result held, beats refused, offered beat not absorbed.
        drv_rdy = 1'b0;
        beats_q = {W'(11), W'(22)};
        send_group(1'b1, 1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = W'(7);
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_sum",       bus.out_sum,       W'(33));
            chk("bp_in_ready",  W'(bus.in_ready),  '0);
            chk("bp_out_valid", W'(bus.out_valid), W'(1));
        end
        drv_rdy = 1'b1;
        tick();
        begin
            exp_t e;
            e.sum = W'(7);
            e.ovf = 1'b0;
            expq.push_back(e);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        wait_idle();

        // Asynchronous reset partway through the resolve pass.
        beats_q = {W'(3), W'(4)};
        send_group(1'b0, 1'b0);
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("rres_out_valid", W'(bus.out_valid), '0);
        chk("rres_in_ready",  W'(bus.in_ready),  W'(1));
        chk("rres_busy",      W'(busy),          '0);
        chk("rres_out_sum",   bus.out_sum,       '0);
        tick();
        rst = 1'b0;
        tick();
        beats_q = {W'(9)};
        send_group(1'b1, 1'b0);
        wait_idle();

        // Random groups with input gaps and random consumer backpressure.
        rdy_rand = 1'b1;
        for (int g = 0; g < 40; g++) begin
            beats_q.delete();
            for (int j = 0; j < $urandom_range(1, 8); j++) begin
                beats_q.push_back(rnd_word());
            end
            send_group(1'b1, 1'b1);
        end
        wait_idle();
        tick();
        chk("queue_drained", W'(expq.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
